alu_exec_unit: RTL and testbench

//  Integer execute stage directly downstream of the reservation station. Each cycle it takes one issued
//  RV32I non-memory op (op, Vj, Vk, imm, pc, rob tag) and computes it. The result is registered and driven

---
 rtl/alu_exec_unit_pkg.sv | 41 ++++
 rtl/alu_exec_unit_core.sv | 61 ++++++
 rtl/alu_exec_unit.sv | 67 ++++++
 tb/tb_alu_exec_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the integer execute stage: op encodings, widths, the ROB "no entry" tag
// and small decode helpers.
package alu_exec_unit_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 5;
   localparam int ROB_W  = 4;

   localparam logic [ROB_W-1:0]  ZERO_ROB  = '0;
   localparam logic [DATA_W-1:0] JALR_MASK = 32'hFFFF_FFFE;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 5'd0,
      OP_ADD   = 5'd1,  OP_SUB   = 5'd2,  OP_SLL   = 5'd3,  OP_SLT   = 5'd4,
      OP_SLTU  = 5'd5,  OP_XOR   = 5'd6,  OP_SRL   = 5'd7,  OP_SRA   = 5'd8,
      OP_OR    = 5'd9,  OP_AND   = 5'd10,
      OP_ADDI  = 5'd11, OP_SLTI  = 5'd12, OP_SLTIU = 5'd13, OP_XORI  = 5'd14,
      OP_ORI   = 5'd15, OP_ANDI  = 5'd16, OP_SLLI  = 5'd17, OP_SRLI  = 5'd18,
      OP_SRAI  = 5'd19,
      OP_LUI   = 5'd20, OP_AUIPC = 5'd21, OP_JAL   = 5'd22, OP_JALR  = 5'd23,
      OP_BEQ   = 5'd24, OP_BNE   = 5'd25, OP_BLT   = 5'd26, OP_BGE   = 5'd27,
      OP_BLTU  = 5'd28, OP_BGEU  = 5'd29
   } op_e;

   // I-type, LUI and AUIPC take the immediate as second operand; everything else uses Vk.
   function automatic logic op_uses_imm(input logic [OP_W-1:0] op);
      logic r;
      r = 1'b0;
      case (op_e'(op))
         OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
         OP_SLLI, OP_SRLI, OP_SRAI, OP_LUI, OP_AUIPC: r = 1'b1;
         default:                                      r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic op_is_defined(input logic [OP_W-1:0] op);
      return (op != OP_NOP) && (op <= OP_BGEU);
   endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational RV32I ALU core: computes the rd result plus branch/jump resolution for one op.
module alu_exec_unit_core
   import alu_exec_unit_pkg::*;
(
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [DATA_W-1:0] i_pc,
   input  logic [DATA_W-1:0] i_imm,
   output logic [DATA_W-1:0] o_result,
   output logic              o_jump,
   output logic [DATA_W-1:0] o_target
);

   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_pc_imm;

   assign w_shamt  = i_b[4:0];
   assign w_pc_imm = i_pc + i_imm;

   always_comb begin
      o_result = '0;
      o_jump   = 1'b0;
      o_target = '0;
      case (op_e'(i_op))
         OP_ADD,  OP_ADDI:  o_result = i_a + i_b;
         OP_SUB:            o_result = i_a - i_b;
         OP_SLL,  OP_SLLI:  o_result = i_a << w_shamt;
         OP_SLT,  OP_SLTI:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
         OP_SLTU, OP_SLTIU: o_result = {31'd0, i_a < i_b};
         OP_XOR,  OP_XORI:  o_result = i_a ^ i_b;
         OP_SRL,  OP_SRLI:  o_result = i_a >> w_shamt;
         OP_SRA,  OP_SRAI:  o_result = $unsigned($signed(i_a) >>> w_shamt);
         OP_OR,   OP_ORI:   o_result = i_a | i_b;
         OP_AND,  OP_ANDI:  o_result = i_a & i_b;
         OP_LUI:            o_result = i_b;
         OP_AUIPC:          o_result = i_pc + i_b;
         OP_JAL: begin
            o_result = i_pc + 32'd4;
            o_jump   = 1'b1;
            o_target = w_pc_imm;
         end
         OP_JALR: begin
            o_result = i_pc + 32'd4;
            o_jump   = 1'b1;
            o_target = (i_a + i_imm) & JALR_MASK;
         end
         OP_BEQ:  o_jump = (i_a == i_b);
         OP_BNE:  o_jump = (i_a != i_b);
         OP_BLT:  o_jump = ($signed(i_a) < $signed(i_b));
         OP_BGE:  o_jump = ($signed(i_a) >= $signed(i_b));
         OP_BLTU: o_jump = (i_a < i_b);
         OP_BGEU: o_jump = (i_a >= i_b);
         default: ;
      endcase
      // Branches report the target only when taken; not-taken leaves target at 0.
      if (o_jump && (i_op >= OP_BEQ))
         o_target = w_pc_imm;
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: selects operands, runs the ALU core and registers the result onto the ALU CDB.
// No handshake: an op is accepted every cycle ena=1 and broadcast exactly one cycle later; ena=0 freezes all.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              flush,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_Vj,
   input  logic [DATA_W-1:0] in_Vk,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [ROB_W-1:0]  in_rob_tag,
   output logic [ROB_W-1:0]  out_cdb_rob_tag,
   output logic [DATA_W-1:0] out_cdb_data,
   output logic              out_jump,
   output logic [DATA_W-1:0] out_target
);

   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_result;
   logic              w_jump;
   logic [DATA_W-1:0] w_target;
   logic              w_live;

   logic [ROB_W-1:0]  r_tag;
   logic [DATA_W-1:0] r_data;
   logic              r_jump;
   logic [DATA_W-1:0] r_target;

   assign w_b    = op_uses_imm(in_op) ? in_imm : in_Vk;
   // Undefined codes and ops without a destination entry behave exactly like NOP.
   assign w_live = op_is_defined(in_op) && (in_rob_tag != ZERO_ROB);

   alu_exec_unit_core u_core (
      .i_op     (in_op),
      .i_a      (in_Vj),
      .i_b      (w_b),
      .i_pc     (in_pc),
      .i_imm    (in_imm),
      .o_result (w_result),
      .o_jump   (w_jump),
      .o_target (w_target)
   );

   always_ff @(posedge clk) begin
      if (rst || flush || (ena && !w_live)) begin
         r_tag    <= ZERO_ROB;
         r_data   <= '0;
         r_jump   <= 1'b0;
         r_target <= '0;
      end else if (ena) begin
         r_tag    <= in_rob_tag;
         r_data   <= w_result;
         r_jump   <= w_jump;
         r_target <= w_target;
      end
   end

   assign out_cdb_rob_tag = r_tag;
   assign out_cdb_data    = r_data;
   assign out_jump        = r_jump;
   assign out_target      = r_target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, one checking task, summary line at the end.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic              clk;
   logic              rst;
   logic              ena;
   logic              flush;
   logic [OP_W-1:0]   in_op;
   logic [DATA_W-1:0] in_Vj;
   logic [DATA_W-1:0] in_Vk;
   logic [DATA_W-1:0] in_imm;
   logic [DATA_W-1:0] in_pc;
   logic [ROB_W-1:0]  in_rob_tag;
   logic [ROB_W-1:0]  out_cdb_rob_tag;
   logic [DATA_W-1:0] out_cdb_data;
   logic              out_jump;
   logic [DATA_W-1:0] out_target;

   int n_checks;
   int n_errors;

   alu_exec_unit dut (
      .clk             (clk),
      .rst             (rst),
      .ena             (ena),
      .flush           (flush),
      .in_op           (in_op),
      .in_Vj           (in_Vj),
      .in_Vk           (in_Vk),
      .in_imm          (in_imm),
      .in_pc           (in_pc),
      .in_rob_tag      (in_rob_tag),
      .out_cdb_rob_tag (out_cdb_rob_tag),
      .out_cdb_data    (out_cdb_data),
      .out_jump        (out_jump),
      .out_target      (out_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one op, clock it in, then sample #1 after the edge.
   task automatic step(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [ROB_W-1:0] tag);
      in_op      = op;
      in_Vj      = vj;
      in_Vk      = vk;
      in_imm     = imm;
      in_pc      = pc;
      in_rob_tag = tag;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [ROB_W-1:0] tag, input logic [31:0] data,
                             input logic jump, input logic [31:0] target);
      check({name, ".tag"},    32'(out_cdb_rob_tag), 32'(tag));
      check({name, ".data"},   out_cdb_data,         data);
      check({name, ".jump"},   32'(out_jump),        32'(jump));
      check({name, ".target"}, out_target,           target);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; ena = 1'b1; flush = 1'b0;

      // Reset with random live ops on the inputs.
      for (int i = 0; i < 2; i++) begin
         step(OP_ADD, $urandom, $urandom, $urandom, $urandom, ROB_W'($urandom_range(1, 15)));
         expect_out("reset", ZERO_ROB, 32'h0, 1'b0, 32'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(OP_NOP, $urandom, $urandom, $urandom, $urandom, 4'd6);
         expect_out("nop", ZERO_ROB, 32'h0, 1'b0, 32'h0);
      end

      step(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd5);
      expect_out("add_ovf", 4'd5, 32'h8000_0000, 1'b0, 32'h0);
      step(OP_SUB, 32'h0, 32'h1, 32'h0, 32'h0, 4'd6);
      expect_out("sub_wrap", 4'd6, 32'hFFFF_FFFF, 1'b0, 32'h0);
      step(OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd1);
      expect_out("slt", 4'd1, 32'h1, 1'b0, 32'h0);
      step(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd2);
      expect_out("sltu", 4'd2, 32'h0, 1'b0, 32'h0);
      // Vk carries junk to confirm I-type ops take the immediate.
      step(OP_SRAI, 32'h8000_0000, 32'h1F, 32'h4, 32'h0, 4'd3);
      expect_out("srai", 4'd3, 32'hF800_0000, 1'b0, 32'h0);
      step(OP_SRLI, 32'h8000_0000, 32'h1F, 32'h4, 32'h0, 4'd4);
      expect_out("srli", 4'd4, 32'h0800_0000, 1'b0, 32'h0);
      step(OP_SLL, 32'h0000_0003, 32'h0000_0024, 32'h0, 32'h0, 4'd8);
      expect_out("sll_shamt5", 4'd8, 32'h0000_0030, 1'b0, 32'h0);
      step(OP_XORI, 32'hF0F0_F0F0, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'd9);
      expect_out("xori", 4'd9, 32'h0F0F_0F0F, 1'b0, 32'h0);
      step(OP_LUI, 32'h1234, 32'h5678, 32'hABCD_E000, 32'h0, 4'd10);
      expect_out("lui", 4'd10, 32'hABCD_E000, 1'b0, 32'h0);
      step(OP_AUIPC, 32'h0, 32'h0, 32'h0000_1000, 32'h0000_0200, 4'd11);
      expect_out("auipc", 4'd11, 32'h0000_1200, 1'b0, 32'h0);

      step(OP_BNE, 32'h3, 32'h4, 32'hFFFF_FFF8, 32'h100, 4'd2);
      expect_out("bne_taken", 4'd2, 32'h0, 1'b1, 32'h0000_00F8);
      step(OP_BEQ, 32'h3, 32'h4, 32'hFFFF_FFF8, 32'h100, 4'd2);
      expect_out("beq_not", 4'd2, 32'h0, 1'b0, 32'h0);
      step(OP_BLT, 32'h1, 32'hFFFF_FFFF, 32'h20, 32'h100, 4'd3);
      expect_out("blt_not", 4'd3, 32'h0, 1'b0, 32'h0);
      step(OP_BLTU, 32'h1, 32'hFFFF_FFFF, 32'h20, 32'h100, 4'd3);
      expect_out("bltu_taken", 4'd3, 32'h0, 1'b1, 32'h0000_0120);
      step(OP_BGE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8, 32'h300, 4'd4);
      expect_out("bge_eq", 4'd4, 32'h0, 1'b1, 32'h0000_0308);

      step(OP_JALR, 32'h1003, 32'h0, 32'h2, 32'h40, 4'd7);
      expect_out("jalr", 4'd7, 32'h44, 1'b1, 32'h0000_1004);
      step(OP_JAL, 32'h0, 32'h0, 32'h10, 32'h40, 4'd7);
      expect_out("jal", 4'd7, 32'h44, 1'b1, 32'h0000_0050);

      step(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0, ZERO_ROB);
      expect_out("zero_tag", ZERO_ROB, 32'h0, 1'b0, 32'h0);
      step(OP_e_undef(), 32'h1, 32'h2, 32'h0, 32'h0, 4'd9);
      expect_out("undef_op", ZERO_ROB, 32'h0, 1'b0, 32'h0);

      // Stall: outputs hold while ena is low, even with new ops presented.
      step(OP_ADD, 32'd10, 32'd20, 32'h0, 32'h0, 4'd3);
      expect_out("pre_stall", 4'd3, 32'd30, 1'b0, 32'h0);
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(OP_JAL, $urandom, $urandom, 32'h40, 32'h80, 4'd12);
         expect_out("stall_hold", 4'd3, 32'd30, 1'b0, 32'h0);
      end
      ena = 1'b1;
      flush = 1'b1;
      step(OP_JAL, 32'h0, 32'h0, 32'h10, 32'h40, 4'd7);
      expect_out("flush", ZERO_ROB, 32'h0, 1'b0, 32'h0);
      flush = 1'b0;
      step(OP_OR, 32'h00F0, 32'h0F00, 32'h0, 32'h0, 4'd13);
      expect_out("post_flush", 4'd13, 32'h0FF0, 1'b0, 32'h0);
      rst = 1'b1;
      step(OP_JAL, 32'h0, 32'h0, 32'h10, 32'h40, 4'd7);
      expect_out("rst_mid", ZERO_ROB, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      step(OP_ANDI, 32'hFF00_FF00, 32'h0, 32'h0F0F_0F0F, 32'h0, 4'd14);
      expect_out("andi", 4'd14, 32'h0F00_0F00, 1'b0, 32'h0);
      ena = 1'b0;
      flush = 1'b1;
      step(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 4'd1);
      expect_out("flush_no_ena", ZERO_ROB, 32'h0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   function automatic logic [OP_W-1:0] OP_e_undef();
      return 5'd31;
   endfunction

endmodule
